aoc_rotation_parser: RTL and testbench
======================================

Name: aoc_rotation_parser

Overview:
- Converts the raw ASCII puzzle byte stream into rotation commands for the dial solver.
- Input lines look like "L68\n" and "R48\n".
- Output is one (direction, distance) command per line, on a valid/ready handshake. The solver drives out_ready=1 permanently.
- Sits between the input-file byte streamer and the dial solver.

Parameters:
- DIST_W, 8: width of out_distance. Values above 2^DIST_W-1 saturate.
- MAX_DIGITS, 3: maximum decimal digits accepted per line. More digits is a format error.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  byte available
- in_data  in  8  ASCII byte
- in_last  in  1  marks final byte of the file; qualified by in_valid
- in_ready  out  1  parser accepts the byte this cycle
- out_valid  out  1  command available
- out_direction  out  1  R=1, L=0
- out_distance  out  DIST_W  decimal distance (saturated)
- out_ready  in  1  downstream accepts the command
- sat  out  1  sticky: some distance saturated
- err  out  1  sticky: some line was malformed
- done  out  1  level: final command has been handed off

Behaviour:
- Reset values: out_valid=0, out_direction=0, out_distance=0, sat=0, err=0, done=0. in_ready=1 after reset. State=IDLE, accumulator=0, digit count=0.
- A byte is consumed when in_valid && in_ready.
- in_ready=0 in EMIT and DONE; in_ready=1 in every other state.
- States:
  - IDLE
    - 'L' or 'R': latch direction, clear the accumulator and digit count, go to DIGITS.
    - CR (0x0D), LF (0x0A) or space: ignored.
    - Any other byte: set err, go to SKIP.
  - DIGITS
    - '0'..'9': acc = acc*10 + (byte-0x30), digit count += 1.
      - Accumulator is DIST_W+4 bits and is clamped to 2^DIST_W-1 after each step; any clamp sets sat.
      - A digit arriving when digit count == MAX_DIGITS: set err, go to SKIP.
    - CR: ignored.
    - LF with digit count>0: load the output registers, go to EMIT.
    - LF with digit count==0: set err, go to IDLE. Nothing is emitted.
    - Any other byte: set err, go to SKIP.
  - SKIP: discard bytes until LF, then go to IDLE.
  - EMIT
    - out_valid=1; out_direction and out_distance are held stable.
    - On out_ready: out_valid drops next cycle, then go to IDLE, or to DONE if the line's terminator carried in_last.
  - DONE: done=1, in_ready=0. Stays here until rst.
- Latency: out_valid rises the cycle after the terminating byte is consumed. In that same cycle in_ready falls.
- Throughput: one command per (line bytes + 1) cycles with out_ready=1.
- in_last handling. in_last is evaluated together with the consumed byte; the normal transition for that byte applies first.
  - On a digit in DIGITS: treated as digit followed by an implicit LF. Emit, then go to DONE after the handshake.
  - On LF or whitespace in IDLE: go directly to DONE, no emit.
  - In SKIP, or on 'L'/'R', or on a digit that is an error: set err, go to DONE, no emit.
- A digit with in_last when digit count == MAX_DIGITS is an error: no emit, go to DONE.
- rst mid-line or mid-EMIT: pending output discarded, all state and flags cleared, next byte starts a fresh line.
- out_valid is never deasserted without a handshake, except by rst.

Optional Feature:
- Macro: AOC_PARSER_STATS_EN.
- Enabled: adds output ports cmd_count[31:0] and err_count[15:0]. Both reset to 0 and saturate at all-ones.
  - cmd_count increments on each out_valid && out_ready.
  - err_count increments on each cycle where err is set by an event, i.e. once per malformed line.
- Disabled: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic lines: stream "L68\nR48\n" with in_last on the final LF and out_ready=1 -> commands (0,68) then (1,48); done=1; err=0; sat=0.
- Backpressure: "R5\r\nL30\n" with out_ready low for 4 cycles during the first emit -> (1,5) is held stable with in_ready=0 throughout; then (0,30) follows; CR is ignored.
- Saturation: "R300\n" with DIST_W=8 -> (1,255) and sat=1. Then "L999\n" -> (0,255). Then "L1000\n" -> err=1, no emit, and parsing resumes on the next line.
- Malformed input: "X5\nL\nR7\n" -> err=1; the only command is (1,7). With stats enabled, err_count=2 and cmd_count=1.
- No trailing newline: "L12" with in_last on '2' -> (0,12) emitted, then done=1. Subsequent in_valid bytes are not accepted (in_ready=0).
- Reset mid-line: send "R4", assert rst for 1 cycle, then send "L9\n" -> only (0,9) is emitted; all flags are 0 afterwards.

Source files
------------

// File: rtl/aoc_rotation_parser.sv
// rtl/aoc_rotation_parser.sv - ASCII rotation line byte stream to (direction, distance) commands
module aoc_rotation_parser #(
    parameter int DIST_W     = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic              out_direction,
    output logic [DIST_W-1:0] out_distance,
    input  logic              out_ready,
    output logic              sat,
    output logic              err,
    output logic              done
`ifdef AOC_PARSER_STATS_EN
    ,
    output logic [31:0]       cmd_count,
    output logic [15:0]       err_count
`endif
);
    localparam int ACC_W = DIST_W + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {4'b0000, {DIST_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    typedef enum logic [2:0] {S_IDLE, S_DIGITS, S_SKIP, S_EMIT, S_DONE} state_t;

    state_t           state;
    logic             dir_q;
    logic             last_q;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] dcnt;

    logic             fire, is_dir, is_digit, is_lf, is_cr, is_ws;
    logic             acc_clamp, err_evt;
    logic [ACC_W-1:0] acc_sum, acc_next;

    assign in_ready = (state != S_EMIT) && (state != S_DONE);

    always_comb begin
        fire      = in_valid && in_ready;
        is_dir    = (in_data == 8'h4C) || (in_data == 8'h52);
        is_digit  = (in_data >= 8'h30) && (in_data <= 8'h39);
        is_lf     = (in_data == 8'h0A);
        is_cr     = (in_data == 8'h0D);
        is_ws     = is_lf || is_cr || (in_data == 8'h20);
        acc_sum   = acc * ACC_W'(10) + ACC_W'(in_data[3:0]);
        acc_clamp = acc_sum > ACC_MAX;
        acc_next  = acc_clamp ? ACC_MAX : acc_sum;
        err_evt   = 1'b0;
        if (fire) begin
            case (state)
                S_IDLE:   err_evt = is_dir ? in_last : !is_ws;
                S_DIGITS: begin
                    if (is_digit)
                        err_evt = (dcnt == CNT_MAX);
                    else if (is_lf || (is_cr && in_last))
                        err_evt = (dcnt == '0);
                    else
                        err_evt = !is_cr;
                end
                default:  err_evt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            dir_q         <= 1'b0;
            last_q        <= 1'b0;
            acc           <= '0;
            dcnt          <= '0;
            out_valid     <= 1'b0;
            out_direction <= 1'b0;
            out_distance  <= '0;
            sat           <= 1'b0;
            err           <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (err_evt)
                err <= 1'b1;
            case (state)
                S_IDLE: if (fire) begin
                    if (is_dir) begin
                        dir_q <= (in_data == 8'h52);
                        acc   <= '0;
                        dcnt  <= '0;
                    end
                    if (in_last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (is_dir) begin
                        state <= S_DIGITS;
                    end else if (!is_ws) begin
                        state <= S_SKIP;
                    end
                end
                S_DIGITS: if (fire) begin
                    if (is_digit && dcnt != CNT_MAX) begin
                        acc  <= acc_next;
                        dcnt <= dcnt + CNT_W'(1);
                        if (acc_clamp)
                            sat <= 1'b1;
                        if (in_last) begin
                            out_valid     <= 1'b1;
                            out_direction <= dir_q;
                            out_distance  <= acc_next[DIST_W-1:0];
                            last_q        <= 1'b1;
                            state         <= S_EMIT;
                        end
                    end else if ((is_lf || (is_cr && in_last)) && dcnt != '0) begin
                        out_valid     <= 1'b1;
                        out_direction <= dir_q;
                        out_distance  <= acc[DIST_W-1:0];
                        last_q        <= in_last;
                        state         <= S_EMIT;
                    end else if (in_last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (is_lf) begin
                        state <= S_IDLE;
                    end else if (!is_cr) begin
                        state <= S_SKIP;
                    end
                end
                S_SKIP: if (fire) begin
                    if (in_last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (is_lf) begin
                        state <= S_IDLE;
                    end
                end
                S_EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (last_q) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DONE:  state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef AOC_PARSER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_count <= '0;
            err_count <= '0;
        end else begin
            if (out_valid && out_ready && cmd_count != '1)
                cmd_count <= cmd_count + 32'd1;
            if (err_evt && err_count != '1)
                err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aoc_rotation_parser.sv
// tb/tb_aoc_rotation_parser.sv - directed and randomized checks of aoc_rotation_parser
module tb_aoc_rotation_parser;
    localparam int MAXD = 3;
    localparam int DMAX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       fixed_ready = 1'b1;
    logic       rand_ready = 1'b0;
    logic       in_ready, out_valid, out_direction, sat, err, done;
    logic [7:0] out_distance;
`ifdef AOC_PARSER_STATS_EN
    logic [31:0] cmd_count;
    logic [15:0] err_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] stim[$];
    bit  exp_err, exp_sat;
    int  exp_errcnt;

    aoc_rotation_parser #(.DIST_W(8), .MAX_DIGITS(MAXD)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_direction(out_direction), .out_distance(out_distance),
        .out_ready(out_ready), .sat(sat), .err(err), .done(done)
`ifdef AOC_PARSER_STATS_EN
        , .cmd_count(cmd_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        out_ready <= rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic       prev_v = 1'b0, prev_r = 1'b0, prev_dir = 1'b0;
    logic [7:0] prev_dist = 8'h00;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_v && !prev_r) begin
                check("hold_valid", out_valid, 1);
                check("hold_dir", out_direction, prev_dir);
                check("hold_dist", out_distance, prev_dist);
            end
            if (out_valid)
                check("in_ready_emit", in_ready, 0);
            if (out_valid && out_ready)
                got_q.push_back({out_direction, out_distance});
        end
        prev_v    <= out_valid && !rst;
        prev_r    <= out_ready;
        prev_dir  <= out_direction;
        prev_dist <= out_distance;
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++)
            stim.push_back(s[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            in_last  = last;
            acc      = in_ready;
            @(posedge clk);
            n++;
        end
        if (!acc)
            check("byte_timeout", 0, 1);
    endtask

    task automatic send_stim(input bit last);
        for (int i = 0; i < stim.size(); i++)
            send_byte(stim[i], last && (i == stim.size() - 1));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        stim.delete();
    endtask

    task automatic settle(input bit need_done);
        int n;
        n = 0;
        while (need_done && !done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (need_done)
            check("done", done, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_cmds(input string tag);
        check({tag, "_ncmd"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_cmd"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_dir", out_direction, 0);
        check("rst_out_dist", out_distance, 0);
        check("rst_sat", sat, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    // Line-at-a-time reference: evaluate each LF-terminated segment as a whole.
    task automatic eval_line(input logic [7:0] seg[$]);
        int  i, n, val;
        bit  bad, dir;
        i = 0;
        while (i < seg.size() && (seg[i] == 8'h0D || seg[i] == 8'h20))
            i++;
        if (i == seg.size())
            return;
        if (seg[i] != 8'h4C && seg[i] != 8'h52) begin
            exp_err = 1;
            exp_errcnt++;
            return;
        end
        dir = (seg[i] == 8'h52);
        val = 0;
        n   = 0;
        bad = 0;
        for (int j = i + 1; j < seg.size(); j++) begin
            if (seg[j] == 8'h0D)
                continue;
            if (seg[j] >= 8'h30 && seg[j] <= 8'h39) begin
                if (n == MAXD) begin
                    bad = 1;
                    break;
                end
                n++;
                val = val * 10 + int'(seg[j]) - 48;
            end else begin
                bad = 1;
                break;
            end
        end
        if (val > DMAX)
            exp_sat = 1;
        if (bad || n == 0) begin
            exp_err = 1;
            exp_errcnt++;
        end else begin
            exp_q.push_back({dir, 8'(val > DMAX ? DMAX : val)});
        end
    endtask

    task automatic model();
        logic [7:0] seg[$];
        exp_err = 0;
        exp_sat = 0;
        exp_errcnt = 0;
        for (int i = 0; i < stim.size(); i++) begin
            if (stim[i] == 8'h0A) begin
                eval_line(seg);
                seg.delete();
            end else begin
                seg.push_back(stim[i]);
            end
        end
        if (seg.size() != 0)
            eval_line(seg);
    endtask

    initial begin
        int nl, nd;
        repeat (3) @(negedge clk);

        // Basic lines
        do_reset();
        push_str("L68\nR48\n");
        send_stim(1);
        settle(1);
        exp_q.push_back({1'b0, 8'd68});
        exp_q.push_back({1'b1, 8'd48});
        check_cmds("basic");
        check("basic_err", err, 0);
        check("basic_sat", sat, 0);

        // Backpressure during the first emit
        do_reset();
        fixed_ready = 1'b0;
        repeat (2) @(negedge clk);
        push_str("R5\015\n");
        send_stim(0);
        for (int k = 0; k < 4; k++) begin
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_dir", out_direction, 1);
            check("bp_dist", out_distance, 5);
            @(negedge clk);
        end
        fixed_ready = 1'b1;
        push_str("L30\n");
        send_stim(1);
        settle(1);
        exp_q.push_back({1'b1, 8'd5});
        exp_q.push_back({1'b0, 8'd30});
        check_cmds("bp");
        check("bp_err", err, 0);

        // Saturation and too many digits
        do_reset();
        push_str("R300\nL999\nL1000\nR1\n");
        send_stim(1);
        settle(1);
        exp_q.push_back({1'b1, 8'd255});
        exp_q.push_back({1'b0, 8'd255});
        exp_q.push_back({1'b1, 8'd1});
        check_cmds("satur");
        check("satur_sat", sat, 1);
        check("satur_err", err, 1);
`ifdef AOC_PARSER_STATS_EN
        check("satur_errcnt", err_count, 1);
        check("satur_cmdcnt", cmd_count, 3);
`endif

        // Malformed lines
        do_reset();
        push_str("X5\nL\nR7\n");
        send_stim(1);
        settle(1);
        exp_q.push_back({1'b1, 8'd7});
        check_cmds("malf");
        check("malf_err", err, 1);
        check("malf_sat", sat, 0);
`ifdef AOC_PARSER_STATS_EN
        check("malf_errcnt", err_count, 2);
        check("malf_cmdcnt", cmd_count, 1);
`endif

        // No trailing newline, then bytes are refused
        do_reset();
        push_str("L12");
        send_stim(1);
        settle(1);
        exp_q.push_back({1'b0, 8'd12});
        check_cmds("nolf");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h52;
            check("nolf_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("nolf_extra", got_q.size(), 0);

        // Reset mid-line
        do_reset();
        push_str("R4");
        send_stim(0);
        do_reset();
        push_str("L9\n");
        send_stim(0);
        settle(0);
        exp_q.push_back({1'b0, 8'd9});
        check_cmds("midrst");
        check("midrst_err", err, 0);
        check("midrst_sat", sat, 0);
        check("midrst_done", done, 0);

        // Randomized streams with random out_ready
        for (int r = 0; r < 12; r++) begin
            do_reset();
            nl = $urandom_range(3, 7);
            for (int l = 0; l < nl; l++) begin
                if ($urandom_range(0, 3) == 0)
                    stim.push_back(8'h20);
                if ($urandom_range(0, 7) == 0)
                    stim.push_back(8'h23);
                else
                    stim.push_back($urandom_range(0, 1) ? 8'h52 : 8'h4C);
                nd = $urandom_range(0, 4);
                for (int d = 0; d < nd; d++) begin
                    if ($urandom_range(0, 9) == 0)
                        stim.push_back(8'h0D);
                    stim.push_back(8'(8'h30 + $urandom_range(0, 9)));
                end
                if ($urandom_range(0, 11) == 0)
                    stim.push_back(8'h78);
                if (l == nl - 1 && $urandom_range(0, 2) == 0) begin
                end else begin
                    if ($urandom_range(0, 2) == 0)
                        stim.push_back(8'h0D);
                    stim.push_back(8'h0A);
                end
            end
            model();
            rand_ready = 1'b1;
            send_stim(1);
            settle(1);
            rand_ready = 1'b0;
            check_cmds("rand");
            check("rand_err", err, exp_err);
            check("rand_sat", sat, exp_sat);
`ifdef AOC_PARSER_STATS_EN
            check("rand_errcnt", err_count, exp_errcnt);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
